// File: rtl/button_event.sv
// Button event decoder: turns a debounced level into press/release/short/long pulses.
// Define AUTO_REPEAT_EN to emit repeat_pulse every REPEAT_TIME cycles while a long press is held.
module button_event #(
   parameter logic PRESS_LEVEL = 1'b0,
   parameter int   LONG_TIME   = 100000000,
   parameter int   REPEAT_TIME = 20000000,
   parameter int   CNT_W       = 27
) (
   input  logic       clk_100_MHz,
   input  logic       rst_n,
   input  logic       sig_in,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       short_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic       held,
   output logic [7:0] event_count,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ARM  = 2'd0,
      IDLE = 2'd1,
      HELD = 2'd2,
      LONG = 2'd3
   } state_t;

   localparam longint MAX_T = (LONG_TIME > REPEAT_TIME) ? LONG_TIME : REPEAT_TIME;

   // The hold counter must reach the larger threshold without wrapping.
   if ((longint'(1) << CNT_W) <= MAX_T || LONG_TIME < 2 || REPEAT_TIME < 2) begin : g_bad_params
      $error("button_event: CNT_W too small or thresholds below 2");
   end

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TIME - 1);
`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TIME - 1);
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             repeat_q, repeat_d;
   logic             held_q, held_d;
   logic [7:0]       event_count_q, event_count_d;
   logic             pressed;

   assign pressed = (sig_in == PRESS_LEVEL);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         // ARM swallows a press that was already in progress when reset lifted.
         ARM: begin
            if (!pressed) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (pressed) begin
               state_d = HELD;
               press_d = 1'b1;
               cnt_d   = '0;
            end
         end
         HELD: begin
            if (!pressed) begin
               state_d   = IDLE;
               release_d = 1'b1;
               short_d   = 1'b1;
            end else if (cnt_q == LONG_LAST) begin
               state_d = LONG;
               long_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         LONG: begin
            if (!pressed) begin
               state_d   = IDLE;
               release_d = 1'b1;
            end else begin
`ifdef AUTO_REPEAT_EN
               if (cnt_q == REP_LAST) begin
                  repeat_d = 1'b1;
                  cnt_d    = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
`else
               cnt_d = cnt_q;
`endif
            end
         end
         default: begin
            state_d = ARM;
         end
      endcase
      held_d        = (state_d == HELD) || (state_d == LONG);
      event_count_d = event_count_q + {7'd0, press_d | repeat_d};
   end

   always_ff @(posedge clk_100_MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ARM;
         cnt_q         <= '0;
         press_q       <= 1'b0;
         release_q     <= 1'b0;
         short_q       <= 1'b0;
         long_q        <= 1'b0;
         repeat_q      <= 1'b0;
         held_q        <= 1'b0;
         event_count_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         press_q       <= press_d;
         release_q     <= release_d;
         short_q       <= short_d;
         long_q        <= long_d;
         repeat_q      <= repeat_d;
         held_q        <= held_d;
         event_count_q <= event_count_d;
      end
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign short_pulse   = short_q;
   assign long_pulse    = long_q;
   assign repeat_pulse  = repeat_q;
   assign held          = held_q;
   assign event_count   = event_count_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_button_event.sv
// Bench for button_event with LONG_TIME=10, REPEAT_TIME=4, active-low button.
// Expected per-cycle outputs are derived arithmetically from press length and queued.
module tb_button_event;

   localparam int   LONG_T = 10;
   localparam int   REP_T  = 4;
   localparam logic PRESS  = 1'b0;

   logic       clk_100_MHz = 1'b0;
   logic       rst_n;
   logic       sig_in;
   logic       press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;
   logic [7:0] event_count;
   logic [1:0] state_dbg;

   button_event #(
      .PRESS_LEVEL(PRESS),
      .LONG_TIME  (LONG_T),
      .REPEAT_TIME(REP_T),
      .CNT_W      (8)
   ) dut (
      .clk_100_MHz  (clk_100_MHz),
      .rst_n        (rst_n),
      .sig_in       (sig_in),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .short_pulse  (short_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .held         (held),
      .event_count  (event_count),
      .state_dbg    (state_dbg)
   );

   always #5 clk_100_MHz = ~clk_100_MHz;

   // Vector layout: {press, release, short, long, repeat, held, event_count[7:0]}
   logic [13:0] exp_q[$];
   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [7:0]  exp_cnt;

   typedef struct {
      int hold;
      int gap;
      int exp_short;
      int exp_long;
      int exp_rep;
   } vec_t;

   vec_t tbl[7];

   function automatic logic [13:0] vec(input logic p, input logic r, input logic s,
                                       input logic l, input logic rp, input logic h,
                                       input logic [7:0] c);
      return {p, r, s, l, rp, h, c};
   endfunction

   function automatic logic [13:0] obs_now();
      return {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held, event_count};
   endfunction

   task automatic check_vec(input string name, input logic [13:0] act, input logic [13:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s t=%0t: got p%b r%b s%b l%b rp%b h%b cnt=%0d, expected p%b r%b s%b l%b rp%b h%b cnt=%0d",
                  name, $time, act[13], act[12], act[11], act[10], act[9], act[8], act[7:0],
                  exp[13], exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one input level, queue its expected outcome, compare after the edge.
   task automatic step(input logic s, input logic [13:0] exp, output logic [13:0] obs);
      logic [13:0] e;
      sig_in = s;
      exp_q.push_back(exp);
      @(posedge clk_100_MHz);
      #1;
      obs = obs_now();
      e = exp_q.pop_front();
      check_vec("cycle", obs, e);
   endtask

   // From IDLE: press for `hold` sampled cycles, then release for `gap`+1 cycles.
   task automatic run_press(input int hold, input int gap,
                            output int n_short, output int n_long, output int n_rep);
      logic [13:0] obs;
      logic        p, r, s, l, rp, h;
      n_short = 0;
      n_long  = 0;
      n_rep   = 0;
      for (int k = 0; k < hold + 1 + gap; k++) begin
         p  = (k == 0);
         h  = (k < hold);
         r  = (k == hold);
         s  = r && (hold <= LONG_T);
         l  = (k == LONG_T) && (k < hold);
         rp = 1'b0;
`ifdef AUTO_REPEAT_EN
         rp = (k < hold) && (k > LONG_T) && (((k - LONG_T) % REP_T) == 0);
`endif
         if (p || rp) exp_cnt = exp_cnt + 8'd1;
         step((k < hold) ? PRESS : ~PRESS, vec(p, r, s, l, rp, h, exp_cnt), obs);
         if (obs[11]) n_short++;
         if (obs[10]) n_long++;
         if (obs[9])  n_rep++;
      end
   endtask

   initial begin
      logic [13:0] obs;
      int          ns, nl, nr;

      tbl[0] = '{hold: 5,  gap: 3, exp_short: 1, exp_long: 0, exp_rep: 0};
      tbl[1] = '{hold: 1,  gap: 2, exp_short: 1, exp_long: 0, exp_rep: 0};
      tbl[2] = '{hold: 10, gap: 2, exp_short: 1, exp_long: 0, exp_rep: 0};
      tbl[3] = '{hold: 11, gap: 2, exp_short: 0, exp_long: 1, exp_rep: 0};
      tbl[4] = '{hold: 9,  gap: 1, exp_short: 1, exp_long: 0, exp_rep: 0};
`ifdef AUTO_REPEAT_EN
      tbl[5] = '{hold: 22, gap: 3, exp_short: 0, exp_long: 1, exp_rep: 2};
      tbl[6] = '{hold: 30, gap: 3, exp_short: 0, exp_long: 1, exp_rep: 4};
`else
      tbl[5] = '{hold: 22, gap: 3, exp_short: 0, exp_long: 1, exp_rep: 0};
      tbl[6] = '{hold: 30, gap: 3, exp_short: 0, exp_long: 1, exp_rep: 0};
`endif

      // Reset with the button already pressed.
      rst_n   = 1'b0;
      sig_in  = PRESS;
      exp_cnt = 8'd0;
      #3;
      check_vec("reset", obs_now(), 14'd0);
      @(negedge clk_100_MHz);
      rst_n = 1'b1;

      // Still pressed after reset: ARM must stay silent.
      for (int i = 0; i < 20; i++) step(PRESS, 14'd0, obs);
      step(~PRESS, 14'd0, obs);
      run_press(3, 2, ns, nl, nr);
      check_int("arm_first_short", ns, 1);

      for (int i = 0; i < 7; i++) begin
         run_press(tbl[i].hold, tbl[i].gap, ns, nl, nr);
         check_int($sformatf("tbl%0d_short", i), ns, tbl[i].exp_short);
         check_int($sformatf("tbl%0d_long", i), nl, tbl[i].exp_long);
         check_int($sformatf("tbl%0d_repeat", i), nr, tbl[i].exp_rep);
      end

      // Enough single-cycle presses to carry event_count through 255 -> 0.
      for (int i = 0; i < 250; i++) run_press(1, 1, ns, nl, nr);
      check_int("wrap_seen", (exp_cnt < 8'd100) ? 1 : 0, 1);

      // Reset asserted between edges on the 7th held cycle.
      exp_cnt = exp_cnt + 8'd1;
      step(PRESS, vec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_cnt), obs);
      for (int k = 1; k < 7; k++) step(PRESS, vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_cnt), obs);
      #2;
      rst_n = 1'b0;
      #1;
      check_vec("async_reset_midhold", obs_now(), 14'd0);
      exp_cnt = 8'd0;
      @(negedge clk_100_MHz);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step(PRESS, 14'd0, obs);
      step(~PRESS, 14'd0, obs);
      run_press(5, 2, ns, nl, nr);
      check_int("post_reset_short", ns, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
